// File: rtl/ysyx_pkg.sv
// Shared constants and the fetch-entry layout for the ysyx instruction-fetch path.
package ysyx_pkg;

    localparam int          IFU_ADDR_W   = 32;
    localparam int          IFU_INST_W   = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Queue entries are packed in this order: {inst, pc, err}.
    typedef struct packed {
        logic [IFU_INST_W-1:0] inst;
        logic [IFU_ADDR_W-1:0] pc;
        logic                  err;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; used as the in-order instruction queue.
module ysyx_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    // A write into a full queue is fine when the head leaves in the same cycle.
    assign push  = wr_en && !flush && (!full || rd_en);
    assign pop   = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ysyx_ifu_prefetch.sv
// Decoupled, pipelined instruction fetcher with credit-limited requests and redirect flush.
// Optional YSYX_IFU_MISALIGN_EN: misaligned redirect yields one faulting entry and halts fetch.
module ysyx_ifu_prefetch
    import ysyx_pkg::*;
#(
    parameter int              ADDR_W   = IFU_ADDR_W,
    parameter int              INST_W   = IFU_INST_W,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    input  logic              resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = INST_W + ADDR_W + 1;

    logic              req_valid_q, req_valid_n;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_n;
    logic              pend_q,      pend_n;
    logic [ADDR_W-1:0] pend_pc_q,   pend_pc_n;
    logic [ADDR_W-1:0] resp_pc_q,   resp_pc_n;
    logic [CNT_W-1:0]  outstanding_q, out_n;
    logic [CNT_W-1:0]  drop_q,      drop_n;
    logic              halt_q,      halt_n;
    logic              fault_q;
    logic [ADDR_W-1:0] fault_pc_q;
    logic [CNT_W-1:0]  count_n;
    logic              credit;

    logic [ADDR_W-1:0] target;
    logic              misalign;

`ifdef YSYX_IFU_MISALIGN_EN
    assign target   = redirect_pc;
    assign misalign = |redirect_pc[1:0];
`else
    assign target   = redirect_pc & ~ADDR_W'(3);
    assign misalign = 1'b0;
`endif

    logic              acc, hold, drop_resp, enq_resp;
    logic              q_push, q_pop, q_empty;
    logic [CNT_W-1:0]  q_count;
    logic [ENT_W-1:0]  q_wdata, q_rdata;

    assign acc       = req_valid_q && req_ready;
    assign hold      = req_valid_q && !req_ready;
    assign drop_resp = resp_valid && (drop_q != '0);
    assign enq_resp  = resp_valid && (drop_q == '0) && !redirect_valid;
    assign q_push    = (enq_resp || fault_q) && !redirect_valid;
    assign q_pop     = inst_valid && inst_ready && !redirect_valid;
    assign q_wdata   = fault_q ? {INST_W'(0), fault_pc_q, 1'b1}
                               : {resp_data, resp_pc_q, resp_err};

    ysyx_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (q_push),
        .wr_data (q_wdata),
        .rd_en   (inst_ready),
        .rd_data (q_rdata),
        .empty   (q_empty),
        .count   (q_count)
    );

    always_comb begin
        out_n       = outstanding_q + CNT_W'(acc) - CNT_W'(resp_valid);
        count_n     = redirect_valid ? '0 : q_count + CNT_W'(q_push) - CNT_W'(q_pop);
        // Every in-flight response, including one accepted now, is stale after a redirect.
        drop_n      = redirect_valid ? out_n
                                     : drop_q - CNT_W'(drop_resp) + CNT_W'(acc && pend_q);
        halt_n      = redirect_valid ? misalign : halt_q;
        credit      = ({1'b0, out_n} + {1'b0, count_n}) < (CNT_W + 1)'(DEPTH);
        req_valid_n = hold || (credit && !halt_n);
        req_addr_n  = req_addr_q;
        pend_n      = pend_q;
        pend_pc_n   = pend_pc_q;
        // A held request keeps its address; the redirect target waits in pend_pc.
        if (hold) begin
            if (redirect_valid) begin
                pend_n    = 1'b1;
                pend_pc_n = target;
            end
        end else if (redirect_valid) begin
            req_addr_n = target;
            pend_n     = 1'b0;
        end else if (acc) begin
            req_addr_n = pend_q ? pend_pc_q : req_addr_q + ADDR_W'(4);
            pend_n     = 1'b0;
        end
        if (redirect_valid)  resp_pc_n = target;
        else if (enq_resp)   resp_pc_n = resp_pc_q + ADDR_W'(4);
        else                 resp_pc_n = resp_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_PC;
            pend_q        <= 1'b0;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            halt_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            req_valid_q   <= req_valid_n;
            req_addr_q    <= req_addr_n;
            pend_q        <= pend_n;
            resp_pc_q     <= resp_pc_n;
            outstanding_q <= out_n;
            drop_q        <= drop_n;
            halt_q        <= halt_n;
            fault_q       <= redirect_valid && misalign;
        end
    end

    always_ff @(posedge clk) begin
        pend_pc_q  <= pend_pc_n;
        fault_pc_q <= target;
    end

    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign inst_valid = !q_empty;
    assign inst       = inst_valid ? q_rdata[ENT_W-1 -: INST_W] : '0;
    assign inst_pc    = inst_valid ? q_rdata[ADDR_W:1] : '0;
    assign inst_err   = inst_valid && q_rdata[0];

endmodule
